// File: rtl/noc_traffic_gen.sv
// Packet source for one NoC injection port: streams head/body/tail flits under valid/ready,
// with run-time body length, packet count, inter-packet gap and fixed or sweep destination.
module noc_traffic_gen #(
  parameter int MAX_BODY = 8,
  parameter int MESH_X   = 4,
  parameter int MESH_Y   = 4,
  parameter int SRC_X    = 0,
  parameter int SRC_Y    = 0,
  parameter int GAP_W    = 8,
  parameter int CNT_W    = 16,
  localparam int BL_W      = $clog2(MAX_BODY) + 1,
  localparam int FLIT_SIZE = 34
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_start,
  input  logic                 i_sweep,
  input  logic [7:0]           i_dest_x,
  input  logic [7:0]           i_dest_y,
  input  logic [BL_W-1:0]      i_body_len,
  input  logic [CNT_W-1:0]     i_num_packets,
  input  logic [GAP_W-1:0]     i_gap,
  output logic [FLIT_SIZE-1:0] o_flit,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CNT_W-1:0]     o_pkt_count,
  output logic [CNT_W-1:0]     o_flit_count
);

  // state | meaning
  // IDLE  | waiting for a rising edge of i_start
  // HEAD  | head flit presented (destination x/y)
  // BODY  | body flits presented, {seq, index}
  // TAIL  | tail flit presented, reserved = seq
  // GAP   | idle cycles between tail and next head
  // DONE  | one-cycle run-complete pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_BODY,
    S_TAIL,
    S_GAP,
    S_DONE
  } state_t;

  // Flit layout: [33:32] type, [31:0] type-specific payload.
  localparam logic [1:0] FT_HEAD = 2'd1;
  localparam logic [1:0] FT_BODY = 2'd2;
  localparam logic [1:0] FT_TAIL = 2'd3;

  localparam logic       SRC_AT_ORIGIN = (SRC_X == 0) && (SRC_Y == 0);
  localparam logic [7:0] PTR0_X = (SRC_AT_ORIGIN && MESH_X > 1) ? 8'd1 : 8'd0;
  localparam logic [7:0] PTR0_Y = (SRC_AT_ORIGIN && MESH_X == 1) ? 8'd1 : 8'd0;

  state_t               state, state_nx;
  logic                 start_q;
  logic                 sweep_q, sweep_nx;
  logic [7:0]           dest_x_q, dest_x_nx;
  logic [7:0]           dest_y_q, dest_y_nx;
  logic [BL_W-1:0]      body_len_q, body_len_nx;
  logic [CNT_W-1:0]     num_pkts_q, num_pkts_nx;
  logic [GAP_W-1:0]     gap_q, gap_nx;
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_nx;
  logic [BL_W-1:0]      idx, idx_nx;
  logic [15:0]          seq, seq_nx;
  logic [7:0]           ptr_x, ptr_x_nx;
  logic [7:0]           ptr_y, ptr_y_nx;
  logic [CNT_W-1:0]     pkt_cnt, pkt_cnt_nx;
  logic [CNT_W-1:0]     flit_cnt, flit_cnt_nx;
  logic [FLIT_SIZE-1:0] flit_q, flit_nx;
  logic                 valid_q, valid_nx;
  logic                 busy_q, busy_nx;
  logic                 done_q, done_nx;

  logic                 xfer;
  logic                 start_rise;
  logic                 limit_hit;
  logic [15:0]          ptr_adv;
  logic [7:0]           head_x, head_y;

  function automatic logic [15:0] ptr_inc(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] nx;
    logic [7:0] ny;
    nx = x + 8'd1;
    ny = y;
    if (x == 8'(MESH_X - 1)) begin
      nx = '0;
      ny = (y == 8'(MESH_Y - 1)) ? 8'd0 : y + 8'd1;
    end
    return {nx, ny};
  endfunction

  function automatic logic [15:0] ptr_step(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = ptr_inc(x, y);
    if (p == {8'(SRC_X), 8'(SRC_Y)}) p = ptr_inc(p[15:8], p[7:0]);
    return p;
  endfunction

  assign xfer       = valid_q & i_ready;
  assign start_rise = i_start & ~start_q;
  assign ptr_adv    = ptr_step(ptr_x, ptr_y);
  assign limit_hit  = (num_pkts_q != '0) && ((pkt_cnt + CNT_W'(1)) == num_pkts_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    sweep_nx    = sweep_q;
    dest_x_nx   = dest_x_q;
    dest_y_nx   = dest_y_q;
    body_len_nx = body_len_q;
    num_pkts_nx = num_pkts_q;
    gap_nx      = gap_q;
    gap_cnt_nx  = gap_cnt;
    idx_nx      = idx;
    seq_nx      = seq;
    ptr_x_nx    = ptr_x;
    ptr_y_nx    = ptr_y;
    pkt_cnt_nx  = pkt_cnt;
    flit_cnt_nx = flit_cnt;

    if (xfer) flit_cnt_nx = flit_cnt + CNT_W'(1);

    case (state)
      S_IDLE: begin
        if (start_rise) begin
          sweep_nx    = i_sweep;
          dest_x_nx   = i_dest_x;
          dest_y_nx   = i_dest_y;
          body_len_nx = (i_body_len > BL_W'(MAX_BODY)) ? BL_W'(MAX_BODY) : i_body_len;
          num_pkts_nx = i_num_packets;
          gap_nx      = i_gap;
          pkt_cnt_nx  = '0;
          flit_cnt_nx = '0;
          seq_nx      = '0;
          state_nx    = S_HEAD;
        end
      end
      S_HEAD: begin
        if (xfer) begin
          idx_nx   = '0;
          state_nx = (body_len_q != '0) ? S_BODY : S_TAIL;
        end
      end
      S_BODY: begin
        if (xfer) begin
          if (idx == body_len_q - BL_W'(1)) state_nx = S_TAIL;
          else idx_nx = idx + BL_W'(1);
        end
      end
      S_TAIL: begin
        if (xfer) begin
          pkt_cnt_nx = pkt_cnt + CNT_W'(1);
          seq_nx     = seq + 16'd1;
          ptr_x_nx   = ptr_adv[15:8];
          ptr_y_nx   = ptr_adv[7:0];
          if (limit_hit || !i_start) begin
            state_nx = S_DONE;
          end else if (gap_q == '0) begin
            state_nx = S_HEAD;
          end else begin
            gap_cnt_nx = gap_q;
            state_nx   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (!i_start) state_nx = S_DONE;
        else if (gap_cnt == GAP_W'(1)) state_nx = S_HEAD;
        else gap_cnt_nx = gap_cnt - GAP_W'(1);
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output flit is built from next-state values so every output is a flop.
  always_comb begin
    head_x   = sweep_nx ? ptr_x_nx : dest_x_nx;
    head_y   = sweep_nx ? ptr_y_nx : dest_y_nx;
    flit_nx  = '0;
    valid_nx = 1'b0;
    case (state_nx)
      S_HEAD: begin
        flit_nx  = {FT_HEAD, 1'b1, head_x, head_y, 15'd0};
        valid_nx = 1'b1;
      end
      S_BODY: begin
        flit_nx  = {FT_BODY, seq_nx, 16'(idx_nx)};
        valid_nx = 1'b1;
      end
      S_TAIL: begin
        flit_nx  = {FT_TAIL, 16'd0, seq_nx};
        valid_nx = 1'b1;
      end
      default: begin
        flit_nx  = '0;
        valid_nx = 1'b0;
      end
    endcase
    busy_nx = (state_nx == S_HEAD) || (state_nx == S_BODY) ||
              (state_nx == S_TAIL) || (state_nx == S_GAP);
    done_nx = (state_nx == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q    <= 1'b0;
      sweep_q    <= 1'b0;
      dest_x_q   <= '0;
      dest_y_q   <= '0;
      body_len_q <= '0;
      num_pkts_q <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
      idx        <= '0;
      seq        <= '0;
      ptr_x      <= PTR0_X;
      ptr_y      <= PTR0_Y;
      pkt_cnt    <= '0;
      flit_cnt   <= '0;
      flit_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      start_q    <= i_start;
      sweep_q    <= sweep_nx;
      dest_x_q   <= dest_x_nx;
      dest_y_q   <= dest_y_nx;
      body_len_q <= body_len_nx;
      num_pkts_q <= num_pkts_nx;
      gap_q      <= gap_nx;
      gap_cnt    <= gap_cnt_nx;
      idx        <= idx_nx;
      seq        <= seq_nx;
      ptr_x      <= ptr_x_nx;
      ptr_y      <= ptr_y_nx;
      pkt_cnt    <= pkt_cnt_nx;
      flit_cnt   <= flit_cnt_nx;
      flit_q     <= flit_nx;
      valid_q    <= valid_nx;
      busy_q     <= busy_nx;
      done_q     <= done_nx;
    end
  end

  assign o_flit       = flit_q;
  assign o_valid      = valid_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_pkt_count  = pkt_cnt;
  assign o_flit_count = flit_cnt;

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Bench for noc_traffic_gen on a 2x2 mesh: directed and randomized runs checked cycle by
// cycle against a packet-level reference model.
module tb_noc_traffic_gen;
  localparam int MX = 2;
  localparam int MY = 2;
  localparam int SX = 0;
  localparam int SY = 0;
  localparam int MAXB = 8;
  localparam int PH_SEND = 0;
  localparam int PH_GAP  = 1;
  localparam int PH_DONE = 2;
  localparam int PH_IDLE = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_sweep = 1'b0;
  logic [7:0]  i_dest_x = '0;
  logic [7:0]  i_dest_y = '0;
  logic [3:0]  i_body_len = '0;
  logic [15:0] i_num_packets = '0;
  logic [7:0]  i_gap = '0;
  logic [33:0] o_flit;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_pkt_count;
  logic [15:0] o_flit_count;

  int errors = 0;
  int checks = 0;
  int ptr;
  logic [15:0] heads[$];
  int pk, fl;

  noc_traffic_gen #(
    .MAX_BODY(MAXB), .MESH_X(MX), .MESH_Y(MY), .SRC_X(SX), .SRC_Y(SY), .GAP_W(8), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_sweep(i_sweep),
    .i_dest_x(i_dest_x), .i_dest_y(i_dest_y), .i_body_len(i_body_len),
    .i_num_packets(i_num_packets), .i_gap(i_gap), .o_flit(o_flit), .o_valid(o_valid),
    .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done),
    .o_pkt_count(o_pkt_count), .o_flit_count(o_flit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sweep order: linear node index y*MX+x, stepping by one and skipping the source node.
  function automatic int next_node(input int p);
    int n;
    n = (p + 1) % (MX * MY);
    if (n == SY * MX + SX) n = (n + 1) % (MX * MY);
    return n;
  endfunction

  function automatic int first_node();
    return (SY * MX + SX == 0) ? 1 : 0;
  endfunction

  function automatic logic [33:0] exp_flit(input int f, input int bl, input int seq,
                                           input logic sw, input logic [7:0] dx,
                                           input logic [7:0] dy, input int p);
    logic [7:0] hx, hy;
    hx = sw ? 8'(p % MX) : dx;
    hy = sw ? 8'(p / MX) : dy;
    if (f == 0) return {2'd1, 1'b1, hx, hy, 15'd0};
    else if (f <= bl) return {2'd2, 16'(seq), 16'(f - 1)};
    else return {2'd3, 16'd0, 16'(seq)};
  endfunction

  // rmode: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  task automatic do_run(input logic sw, input logic [7:0] dx, input logic [7:0] dy,
                        input int bl_in, input int np, input int gap, input int rmode,
                        input int stop_at, input int rst_at,
                        output int pkts_out, output int flits_out);
    int phase, f, flits, pkts, seq, g, cyc, bl;
    logic ev, rdy, xfer;
    bl = (bl_in > MAXB) ? MAXB : bl_in;
    heads.delete();
    i_start = 1'b0;
    i_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_sweep = sw; i_dest_x = dx; i_dest_y = dy; i_body_len = 4'(bl_in);
    i_num_packets = 16'(np); i_gap = 8'(gap); i_start = 1'b1;
    @(posedge clk);
    #1;
    i_sweep = 1'($urandom); i_dest_x = 8'($urandom); i_dest_y = 8'($urandom);
    i_body_len = 4'($urandom); i_num_packets = 16'($urandom); i_gap = 8'($urandom);
    phase = PH_SEND; f = 0; flits = 0; pkts = 0; seq = 0; g = 0; cyc = 0;
    while (phase != PH_IDLE && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      ev = (phase == PH_SEND);
      chk("valid", o_valid, ev);
      chk("flit", o_flit, ev ? exp_flit(f, bl, seq, sw, dx, dy, ptr) : 34'd0);
      chk("busy", o_busy, (phase == PH_SEND) || (phase == PH_GAP));
      chk("done", o_done, phase == PH_DONE);
      chk("pkt_count", o_pkt_count, 16'(pkts));
      chk("flit_count", o_flit_count, 16'(flits));
      if (rst_at > 0 && phase == PH_SEND && flits == rst_at) begin
        #2 reset_n = 1'b0; i_start = 1'b0; i_ready = 1'b0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_flit", o_flit, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_pkt_count", o_pkt_count, 0);
        chk("rst_flit_count", o_flit_count, 0);
        ptr = first_node();
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        repeat (5) begin
          @(negedge clk);
          chk("post_rst_valid", o_valid, 0);
          chk("post_rst_busy", o_busy, 0);
        end
        pkts_out = 0; flits_out = 0;
        return;
      end
      case (rmode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 4 == 1) || (cyc % 4 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (stop_at > 0 && flits >= stop_at) i_start = 1'b0;
      i_ready = rdy;
      xfer = ev && rdy;
      if (xfer && f == 0) heads.push_back({o_flit[30:23], o_flit[22:15]});
      @(posedge clk);
      case (phase)
        PH_SEND: if (xfer) begin
          flits++;
          if (f == bl + 1) begin
            pkts++; seq++; ptr = next_node(ptr); f = 0;
            if ((np != 0 && pkts == np) || !i_start) phase = PH_DONE;
            else if (gap != 0) begin phase = PH_GAP; g = gap; end
          end else f++;
        end
        PH_GAP: if (!i_start) phase = PH_DONE;
                else begin g--; if (g == 0) phase = PH_SEND; end
        default: phase = PH_IDLE;
      endcase
    end
    chk("run_end", phase, PH_IDLE);
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid", o_valid, 0);
      chk("idle_busy", o_busy, 0);
      chk("idle_done", o_done, 0);
      chk("hold_pkt_count", o_pkt_count, 16'(pkts));
      chk("hold_flit_count", o_flit_count, 16'(flits));
    end
    pkts_out = pkts; flits_out = flits;
  endtask

  initial begin
    ptr = first_node();
    #12;
    chk("reset_valid", o_valid, 0);
    chk("reset_flit", o_flit, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_pkt_count", o_pkt_count, 0);
    chk("reset_flit_count", o_flit_count, 0);
    @(negedge clk);
    reset_n = 1'b1;

    do_run(1'b0, 8'd2, 8'd1, 2, 1, 0, 0, 0, 0, pk, fl);
    chk("t1_pkt_count", o_pkt_count, 1);
    chk("t1_flit_count", o_flit_count, 4);
    chk("t1_head_dest", heads[0], 16'h0201);

    do_run(1'b0, 8'd2, 8'd1, 2, 1, 0, 1, 0, 0, pk, fl);
    chk("t2_flit_count", o_flit_count, 4);

    do_run(1'b0, 8'd3, 8'd3, 0, 3, 2, 0, 0, 0, pk, fl);
    chk("t3_pkt_count", o_pkt_count, 3);
    chk("t3_flit_count", o_flit_count, 6);

    do_run(1'b0, 8'd1, 8'd1, 2, 0, 1, 0, 5, 0, pk, fl);
    chk("t4_stop_pkt_count", o_pkt_count, 2);
    chk("t4_stop_flit_count", o_flit_count, 8);
    do_run(1'b0, 8'd0, 8'd1, 1, 1, 0, 0, 0, 0, pk, fl);
    chk("t4_restart_pkt_count", o_pkt_count, 1);

    do_run(1'b1, 8'd0, 8'd0, 13, 1, 0, 2, 0, 0, pk, fl);
    chk("sat_flit_count", o_flit_count, MAXB + 2);

    do_run(1'b0, 8'd2, 8'd2, 4, 0, 0, 0, 0, 2, pk, fl);

    do_run(1'b1, 8'd0, 8'd0, 1, 4, 0, 0, 0, 0, pk, fl);
    chk("sweep_head0", heads[0], 16'h0100);
    chk("sweep_head1", heads[1], 16'h0001);
    chk("sweep_head2", heads[2], 16'h0101);
    chk("sweep_head3", heads[3], 16'h0100);

    for (int r = 0; r < 10; r++) begin
      int np, st;
      np = $urandom_range(1, 4);
      st = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
      do_run(1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 11), np,
             $urandom_range(0, 3), 2, st, 0, pk, fl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/noc_traffic_gen.md
Name: noc_traffic_gen

Overview:
- Parametrised packet source for NoC bring-up and router stress testing. Drives one router injection port with complete head/body/tail packets in the router_pkg FLIT_t format.
- Flits stream directly under a valid/ready handshake; there is no internal flit FIFO.
- Body length, packet count, inter-packet gap and destination (fixed or mesh sweep) are set at run time.
- Per-run packet and flit counters feed scoreboards.

Parameters:
MAX_BODY, 8, maximum body flits per packet; i_body_len saturates to this value.
MESH_X, 4, mesh width used by sweep mode.
MESH_Y, 4, mesh height used by sweep mode.
SRC_X, 0, x coordinate of this generator; skipped in sweep mode.
SRC_Y, 0, y coordinate of this generator; skipped in sweep mode.
GAP_W, 8, width of the inter-packet gap counter.
CNT_W, 16, width of the packet and flit counters.

Ports:
clk  in  1  clock.
reset_n  in  1  asynchronous active-low reset.
i_start  in  1  run enable; a rising edge starts a run; deasserting it requests a graceful stop.
i_sweep  in  1  0 = fixed destination; 1 = sweep all mesh nodes except the source.
i_dest_x  in  8  fixed destination x.
i_dest_y  in  8  fixed destination y.
i_body_len  in  $clog2(MAX_BODY)+1  body flits per packet; 0 is allowed.
i_num_packets  in  CNT_W  packets per run; 0 = unlimited.
i_gap  in  GAP_W  idle cycles between a tail and the next head.
o_flit  out  FLIT_SIZE  current flit (FLIT_t); '0 whenever o_valid=0.
o_valid  out  1  flit valid.
i_ready  in  1  downstream accepts the flit this cycle.
o_busy  out  1  high from HEAD through GAP.
o_done  out  1  one-cycle pulse when a run ends.
o_pkt_count  out  CNT_W  packets whose tail has been accepted in this run.
o_flit_count  out  CNT_W  flits accepted in this run.

Behaviour:
- Reset values:
  - State is IDLE.
  - o_flit, o_valid, o_busy, o_done, o_pkt_count and o_flit_count are 0.
  - The start edge register is 0.
  - The sweep pointer is (0,0), or the next node after it if (0,0) is the source.
- All outputs are registered.
- A transfer occurs on a clock edge where o_valid && i_ready.
- While a flit is stalled (o_valid=1, i_ready=0), o_flit stays bit-stable.
- States: IDLE, HEAD, BODY, TAIL, GAP, DONE.
- IDLE:
  - A rising edge of i_start, sampled at edge N, does the following:
    - Latches i_sweep, i_dest_x, i_dest_y, i_body_len (saturated to MAX_BODY), i_num_packets and i_gap.
    - Clears both counters and the packet sequence number.
    - Moves to HEAD; o_valid=1 from cycle N+1.
  - A level-high i_start without an edge does not restart a run.
- HEAD:
  - head.valid=1, flit_type=HEAD_FLIT.
  - xaddr/yaddr come from the latched fixed destination, or from the sweep pointer when sweep is set.
  - On transfer: go to BODY if body_len>0, otherwise to TAIL.
- BODY:
  - body.data = {packet seq, body index}, zero-extended or truncated to the field width. Packet seq occupies the upper 16 bits; body index starts at 0.
  - The body index increments on each transfer.
  - After the transfer of body index body_len-1, go to TAIL.
- TAIL:
  - tail.reserved = packet seq.
  - On transfer:
    - Increment pkt_count and packet seq (both wrap).
    - Advance the sweep pointer: x+1; at MESH_X-1 wrap x to 0 and increment y; at (MESH_X-1, MESH_Y-1) wrap to (0,0). Skip (SRC_X, SRC_Y).
    - Go to DONE if the packet limit is reached (num_packets≠0 and pkt_count+1==num_packets) or i_start is low. Otherwise go to GAP.
- GAP:
  - o_valid=0; the gap counter counts down the latched i_gap.
  - With gap=0 the next head is issued on the cycle after the tail transfer; GAP is occupied for 0 cycles.
  - If i_start drops during GAP, go to DONE.
- DONE: o_done=1 for one cycle, then IDLE. Counters hold their values until the next start.
- flit_count increments on every transfer.
- A stop request (i_start low) never truncates a packet. The current packet completes through its tail.
- i_ready high while o_valid=0 has no effect.
- Config inputs are ignored outside IDLE.
- Asserting reset mid-packet returns all outputs to their reset values immediately. No partial packet is resumed.

Test Plan:
- Fixed dest (2,1), body_len=2, num_packets=1, gap=0, i_ready=1 -> flits HEAD(2,1), BODY seq0/idx0, BODY seq0/idx1, TAIL reserved=0 on 4 consecutive cycles; o_done pulse; pkt_count=1, flit_count=4.
- Same run with i_ready toggling 1,0,0,1,… -> every flit is held stable across its stall cycles; same 4 flits in order; flit_count=4.
- body_len=0, num_packets=3, gap=2 -> HEAD,TAIL pairs with exactly 2 invalid cycles between each tail and the next head; pkt_count=3.
- Sweep on, MESH 2x2, SRC (0,0), num_packets=4 -> head destinations (1,0),(0,1),(1,1),(1,0).
- num_packets=0, drop i_start during the second packet's first BODY -> packet completes through its tail; DONE; pkt_count=2; a new rising edge restarts with counters cleared.
- reset_n low mid-BODY -> o_valid, o_flit and counters are 0 asynchronously; after release the block stays IDLE until an i_start edge.
